seq_det_ctrl: RTL
=================

# seq_det_ctrl

Run controller for the serial pattern detector. It accepts a programmable pattern and a bit-window length, arms on a start/busy/done handshake and feeds valid serial bits into a shift-compare match core. It counts matches and records the position of the first match over exactly the programmed number of bits. It sits between the serial bit source and the status/host logic, replacing the free-running fixed 10010 detector with a sequenced, configurable run.

## Interface
- PAT_W, 5, pattern length in bits (≥2)
- CNT_W, 8, match counter width
- WIN_W, 16, window length / bit index width
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  start a run; sampled only in IDLE
- abort  input  1  terminate a run, return to IDLE without done
- cfg_pat  input  PAT_W  pattern, MSB is the oldest bit (10010 = 5'b10010)
- cfg_win  input  WIN_W  number of valid bits in the run
- data_in  input  1  serial bit
- data_vld  input  1  data_in valid this cycle
- busy  output  1  run in progress
- done  output  1  one-cycle pulse at run end
- match_pulse  output  1  one-cycle pulse per counted match
- match_cnt  output  CNT_W  matches in the current or last run; saturates at all-ones
- first_pos  output  WIN_W  1-based index of the bit that completed the first match; all-ones if there was no match

## Operation
- States: IDLE, RUN, DONE.
- IDLE: busy=0. On start=1, the block latches cfg_pat and cfg_win, clears history, bit counter, match_cnt and match_cnt state, sets first_pos to all-ones, and moves to RUN. If the latched cfg_win is 0, it moves to DONE instead.
- RUN: busy=1.
  - On each data_vld, data_in shifts into the history (LSB in). bit_idx increments.
  - A match occurs when at least PAT_W bits have been accepted since the last clear and history equals the latched pattern.
  - On a match: match_pulse=1 and match_cnt increments, saturating. If this is the first match, first_pos = bit_idx of this bit.
  - When bit_idx reaches the latched window, the state moves to DONE.
- DONE: done=1, busy=0 for one cycle, then IDLE. match_cnt and first_pos hold until the next start.
- abort in RUN or DONE: IDLE next cycle, done is not pulsed, and counters hold their values. abort takes priority over window completion in the same cycle.
- start while busy is ignored. data_vld in IDLE or DONE is ignored.
- cfg_* changes after start have no effect on the current run.

## Timing
- Reset values: busy=0, done=0, match_pulse=0, match_cnt=0, first_pos=all-ones, state IDLE, history=0.
- Run start: start at edge k gives busy=1 from cycle k+1. data_vld in cycle k is not accepted. The first bit is accepted at edge k+1.
- Match latency: match_pulse is registered and high in the cycle after the data_vld cycle carrying the completing bit.
- Run end: done is high in the cycle after the last window bit is accepted.
  - If the last bit completes a match, match_pulse and done are high in the same cycle, and match_cnt already includes that match.
- Start-to-done with cfg_win=0: done is high in cycle k+1, busy stays 0, and match_cnt=0.
- rst mid-run: all outputs return to reset values at the next edge, with no done pulse.

## Configuration
- SEQ_DET_OVERLAP_EN defined: overlapping matches count, and history is not cleared on a match. Pattern 10010 on stream 10010010 gives 2 matches.
- Undefined: after each match, history and the since-clear bit count are cleared, so the next match needs PAT_W fresh bits. The same stream gives 1 match.

## Structure
- Shared package seq_det_pkg holds:
  - the state enum (IDLE, RUN, DONE)
  - the default pattern constant 5'b10010
  - default PAT_W, CNT_W and WIN_W
- Sub-module seq_match_core holds the PAT_W shift register, the since-clear fill counter and the compare logic. It has inputs shift_en, clear, bit, pattern and output hit.
- The overlap macro is applied inside seq_match_core.

## Test plan
- Reset mid-run: pattern 10010, window 20, assert rst after 7 bits → next cycle busy=0, match_cnt=0, first_pos=16'hFFFF, and no done.
- Overlap: pattern 10010, window 8, stream 1,0,0,1,0,0,1,0 with data_vld continuous.
  - With macro: match_cnt=2 and first_pos=5.
  - Without macro: match_cnt=1 and first_pos=5.
  - done arrives 1 cycle after the 8th bit, coincident with match_pulse in the overlap build.
- Gapped valid: same stream with data_vld low every other cycle → same counts as the continuous case, and match_pulse fires only after valid bits.
- Zero window: cfg_win=0, start → done in the next cycle, match_cnt=0, busy never high.
- Saturation: CNT_W=2, pattern 11, window 10, all ones, macro defined → match_cnt=3 (saturated), with 9 match_pulses.
- Abort and ignored start: abort after 3 bits → IDLE with no done. A start pulsed during RUN has no effect, and a following start in IDLE begins a fresh run with match_cnt cleared.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types and defaults for the serial pattern detector run controller.
// Holds the run-state enum, the legacy 10010 pattern and the default widths.
package seq_det_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_PAT_W = 5;
   localparam int DEF_CNT_W = 8;
   localparam int DEF_WIN_W = 16;

   localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 5'b10010;

endpackage

// File: rtl/seq_det_ctrl_if.sv
// seq_det_ctrl_if: host/bit-source side bundle of the run controller.
// master drives run control, configuration and serial bits; slave is the controller.
interface seq_det_ctrl_if
   import seq_det_pkg::*;
#(
   parameter int PAT_W = DEF_PAT_W,
   parameter int CNT_W = DEF_CNT_W,
   parameter int WIN_W = DEF_WIN_W
) ();

   logic             start;
   logic             abort;
   logic [PAT_W-1:0] cfg_pat;
   logic [WIN_W-1:0] cfg_win;
   logic             data_in;
   logic             data_vld;
   logic             busy;
   logic             done;
   logic             match_pulse;
   logic [CNT_W-1:0] match_cnt;
   logic [WIN_W-1:0] first_pos;

   modport master (
      output start,
      output abort,
      output cfg_pat,
      output cfg_win,
      output data_in,
      output data_vld,
      input  busy,
      input  done,
      input  match_pulse,
      input  match_cnt,
      input  first_pos
   );

   modport slave (
      input  start,
      input  abort,
      input  cfg_pat,
      input  cfg_win,
      input  data_in,
      input  data_vld,
      output busy,
      output done,
      output match_pulse,
      output match_cnt,
      output first_pos
   );

endinterface

// File: rtl/seq_match_core.sv
// seq_match_core: PAT_W-bit shift history, since-clear fill counter and pattern compare.
// SEQ_DET_OVERLAP_EN keeps history across matches; otherwise each match restarts the fill.
module seq_match_core #(
   parameter int PAT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_shift_en,
   input  logic             i_clear,
   input  logic             i_bit,
   input  logic [PAT_W-1:0] i_pattern,
   output logic             o_hit
);

   localparam int FILL_W = $clog2(PAT_W);

   logic [PAT_W-1:0]  r_hist;
   logic [FILL_W-1:0] r_fill;
   logic [PAT_W-1:0]  w_nextHist;
   logic              w_full;

   // The hit is judged on the history as it will be once this bit is in,
   // so the registered pulse lands in the cycle right after the bit.
   assign w_nextHist = {r_hist[PAT_W-2:0], i_bit};
   assign w_full     = (r_fill == FILL_W'(PAT_W - 1));
   assign o_hit      = i_shift_en && w_full && (w_nextHist == i_pattern);

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_hist <= '0;
         r_fill <= '0;
      end else if (i_shift_en) begin
`ifdef SEQ_DET_OVERLAP_EN
         r_hist <= w_nextHist;
         if (!w_full) begin
            r_fill <= r_fill + 1'b1;
         end
`else
         if (o_hit) begin
            r_hist <= '0;
            r_fill <= '0;
         end else begin
            r_hist <= w_nextHist;
            if (!w_full) begin
               r_fill <= r_fill + 1'b1;
            end
         end
`endif
      end
   end

endmodule

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: sequenced run controller around seq_match_core.
// Latches pattern/window on start, counts matches and records the first match position.
module seq_det_ctrl
   import seq_det_pkg::*;
#(
   parameter int PAT_W = DEF_PAT_W,
   parameter int CNT_W = DEF_CNT_W,
   parameter int WIN_W = DEF_WIN_W
) (
   input logic           clk,
   input logic           rst,
   seq_det_ctrl_if.slave bus
);

   state_t           r_state;
   logic [PAT_W-1:0] r_pat;
   logic [WIN_W-1:0] r_win;
   logic [WIN_W-1:0] r_bitIdx;
   logic [CNT_W-1:0] r_matchCnt;
   logic [WIN_W-1:0] r_firstPos;
   logic             r_busy;
   logic             r_done;
   logic             r_matchPulse;

   logic             w_clear;
   logic             w_shiftEn;
   logic             w_hit;
   logic [WIN_W-1:0] w_nextIdx;

   // Abort blocks the bit it arrives with, so nothing moves on an aborted cycle.
   assign w_clear   = (r_state == IDLE) && bus.start;
   assign w_shiftEn = (r_state == RUN) && bus.data_vld && !bus.abort;
   assign w_nextIdx = r_bitIdx + 1'b1;

   seq_match_core #(
      .PAT_W(PAT_W)
   ) u_core (
      .clk       (clk),
      .rst       (rst),
      .i_shift_en(w_shiftEn),
      .i_clear   (w_clear),
      .i_bit     (bus.data_in),
      .i_pattern (r_pat),
      .o_hit     (w_hit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_pat        <= PAT_W'(DEF_PATTERN);
         r_win        <= '0;
         r_bitIdx     <= '0;
         r_matchCnt   <= '0;
         r_firstPos   <= '1;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_matchPulse <= 1'b0;
      end else begin
         r_done       <= 1'b0;
         r_matchPulse <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_pat      <= bus.cfg_pat;
                  r_win      <= bus.cfg_win;
                  r_bitIdx   <= '0;
                  r_matchCnt <= '0;
                  r_firstPos <= '1;
                  if (bus.cfg_win == '0) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= RUN;
                     r_busy  <= 1'b1;
                  end
               end
            end

            RUN: begin
               if (bus.abort) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else if (bus.data_vld) begin
                  r_bitIdx <= w_nextIdx;
                  // A zero count means no match yet this run, even once the count saturates later.
                  if (w_hit) begin
                     r_matchPulse <= 1'b1;
                     if (r_matchCnt == '0) begin
                        r_firstPos <= w_nextIdx;
                     end
                     if (r_matchCnt != '1) begin
                        r_matchCnt <= r_matchCnt + 1'b1;
                     end
                  end
                  if (w_nextIdx == r_win) begin
                     r_state <= DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end

            DONE: begin
               r_state <= IDLE;
            end

            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.match_pulse = r_matchPulse;
   assign bus.match_cnt   = r_matchCnt;
   assign bus.first_pos   = r_firstPos;

endmodule
